// File: rtl/config_latch_bank_pkg.sv
// Shared state encoding and default geometry for the configuration latch bank controller.
// CONFIG_LATCH_BANK_READBACK_EN adds the VERIFY state used by the readback check.
package config_latch_bank_pkg;

  localparam int DEF_NUM_BL          = 8;
  localparam int DEF_NUM_WL          = 16;
  localparam int DEF_WL_PULSE_CYCLES = 2;
  localparam int DEF_RST_CYCLES      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LRST   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETUP  = 3'd3,
    ST_PULSE  = 3'd4,
    ST_HOLD   = 3'd5,
`ifdef CONFIG_LATCH_BANK_READBACK_EN
    ST_VERIFY = 3'd7,
`endif
    ST_DONE   = 3'd6
  } state_t;

  function automatic int clamp_min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/config_latch_bank_timer.sv
// Down-counter shared by the latch-reset and word-line pulse phases.
// zero is high whenever the count has run out.
module config_latch_bank_timer #(
  parameter int W = 4
) (
  input  logic         prog_clk,
  input  logic         prog_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_r;

  // Load has priority over counting; the count parks at zero.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/config_latch_bank_ctrl.sv
// Frame sequencer for a bit-line/word-line configuration latch array.
// CONFIG_LATCH_BANK_READBACK_EN adds q_rb/err and a per-word VERIFY cycle.
module config_latch_bank_ctrl
  import config_latch_bank_pkg::*;
#(
  parameter int NUM_BL          = DEF_NUM_BL,
  parameter int NUM_WL          = DEF_NUM_WL,
  parameter int WL_PULSE_CYCLES = DEF_WL_PULSE_CYCLES,
  parameter int RST_CYCLES      = DEF_RST_CYCLES
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              din_valid,
  input  logic [NUM_BL-1:0] din_data,
  output logic              din_ready,
  output logic              latch_resetb,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic              busy,
  output logic              done
`ifdef CONFIG_LATCH_BANK_READBACK_EN
  ,
  input  logic [NUM_BL-1:0] q_rb,
  output logic              err
`endif
);

  localparam int CW    = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int P_EFF = clamp_min1(WL_PULSE_CYCLES);
  localparam int R_EFF = clamp_min1(RST_CYCLES);
  localparam int T_MAX = (P_EFF > R_EFF) ? P_EFF : R_EFF;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CW-1:0] LAST_COL   = CW'(NUM_WL - 1);
  localparam logic [CW-1:0] COL_ONE    = CW'(1);
  localparam logic [TW-1:0] RST_LOAD   = TW'(R_EFF - 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(P_EFF - 1);

  state_t            state_r;
  logic [CW-1:0]     col_r;
  logic              t_load_s;
  logic              t_en_s;
  logic              t_zero_s;
  logic [TW-1:0]     t_val_s;
  logic [NUM_WL-1:0] col_onehot_s;

  // Timer is loaded on entry to LRST/PULSE and counts while in them.
  always_comb begin
    t_load_s = 1'b0;
    t_val_s  = PULSE_LOAD;
    t_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        t_load_s = start;
        t_val_s  = RST_LOAD;
      end
      ST_SETUP:          t_load_s = 1'b1;
      ST_LRST, ST_PULSE: t_en_s   = 1'b1;
      default:           t_en_s   = 1'b0;
    endcase
  end

  // One-hot decode of the current column.
  always_comb begin
    col_onehot_s        = '0;
    col_onehot_s[col_r] = 1'b1;
  end

  config_latch_bank_timer #(.W(TW)) u_timer (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load       (t_load_s),
    .load_val   (t_val_s),
    .en         (t_en_s),
    .zero       (t_zero_s)
  );

  // Frame sequencer; every output is registered alongside the state.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_r      <= ST_IDLE;
      col_r        <= '0;
      wl           <= '0;
      bl           <= '0;
      latch_resetb <= 1'b1;
      din_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef CONFIG_LATCH_BANK_READBACK_EN
      err          <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_LRST;
            latch_resetb <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            col_r        <= '0;
`ifdef CONFIG_LATCH_BANK_READBACK_EN
            err          <= 1'b0;
`endif
          end
        end
        ST_LRST: begin
          if (t_zero_s) begin
            state_r      <= ST_WAIT;
            latch_resetb <= 1'b1;
            din_ready    <= 1'b1;
            col_r        <= '0;
          end
        end
        ST_WAIT: begin
          if (din_valid && din_ready) begin
            bl        <= din_data;
            din_ready <= 1'b0;
            state_r   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          wl      <= col_onehot_s;
          state_r <= ST_PULSE;
        end
        ST_PULSE: begin
          if (t_zero_s) begin
            wl      <= '0;
            state_r <= ST_HOLD;
          end
        end
`ifdef CONFIG_LATCH_BANK_READBACK_EN
        ST_HOLD: state_r <= ST_VERIFY;
        ST_VERIFY: begin
          if (q_rb != bl) begin
            err <= 1'b1;
          end
          if (col_r == LAST_COL) begin
            state_r <= ST_DONE;
          end else begin
            col_r     <= col_r + COL_ONE;
            din_ready <= 1'b1;
            state_r   <= ST_WAIT;
          end
        end
`else
        ST_HOLD: begin
          if (col_r == LAST_COL) begin
            state_r <= ST_DONE;
          end else begin
            col_r     <= col_r + COL_ONE;
            din_ready <= 1'b1;
            state_r   <= ST_WAIT;
          end
        end
`endif
        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          wl           <= '0;
          latch_resetb <= 1'b1;
          din_ready    <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_latch_bank_ctrl.sv
// Directed self-checking bench: a default-geometry instance plus a single-word instance.
// Builds with or without CONFIG_LATCH_BANK_READBACK_EN.
module tb_config_latch_bank_ctrl;

`ifdef CONFIG_LATCH_BANK_READBACK_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  // 1 + 4 + 16*(3+2) + 1, plus one VERIFY cycle per word when readback is built in
  localparam int LAT_FULL  = 86 + 16 * VER;
  // 1 + 4 + (3+1) + 1 for NUM_WL=1, WL_PULSE_CYCLES=0
  localparam int LAT_SMALL = 10 + VER;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic        prog_reset, start, din_valid, din_ready, latch_resetb, busy, done;
  logic [7:0]  din_data, bl;
  logic [15:0] wl;
  logic        start1, din_valid1, din_ready1, latch_resetb1, busy1, done1;
  logic [7:0]  din_data1, bl1;
  logic [0:0]  wl1;
`ifdef CONFIG_LATCH_BANK_READBACK_EN
  logic [7:0]  q_rb, q_rb1;
  logic        err, err1;
`endif

  config_latch_bank_ctrl dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
    .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
    .latch_resetb(latch_resetb), .bl(bl), .wl(wl), .busy(busy), .done(done)
`ifdef CONFIG_LATCH_BANK_READBACK_EN
    , .q_rb(q_rb), .err(err)
`endif
  );

  config_latch_bank_ctrl #(.NUM_WL(1), .WL_PULSE_CYCLES(0)) dut1 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start1),
    .din_valid(din_valid1), .din_data(din_data1), .din_ready(din_ready1),
    .latch_resetb(latch_resetb1), .bl(bl1), .wl(wl1), .busy(busy1), .done(done1)
`ifdef CONFIG_LATCH_BANK_READBACK_EN
    , .q_rb(q_rb1), .err(err1)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  int rst_low, pulse_cnt, order_err, width_err, bl_err, viol, stall_viol, stall_taken;
  int cur_w, last_idx, word_idx, stall_word, stall_len, stall_left, inject_word, rst_word;
  int err_at2, err_at3;
  logic [15:0] prev_wl;
  logic data_mode, injected, rst_hit, rb_bad;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
  endtask

  function automatic logic [7:0] pat(input int k);
    logic [7:0] v;
    v = 8'(k * 29);
    return data_mode ? (8'h3C ^ v) : 8'hA5;
  endfunction

  task automatic clear_mon();
    rst_low = 0; pulse_cnt = 0; order_err = 0; width_err = 0; bl_err = 0; viol = 0;
    stall_viol = 0; stall_taken = 0; cur_w = 0; last_idx = -1; word_idx = 0;
    stall_left = stall_len; injected = 1'b0; rst_hit = 1'b0; prev_wl = '0;
    err_at2 = -1; err_at3 = -1;
  endtask

  // One cycle: sample outputs at the falling edge, then set inputs for the next rising edge.
  task automatic tick();
    int idx;
    @(negedge prog_clk);
    idx = -1;
    for (int i = 0; i < 16; i++) if (wl[i]) idx = i;
    if (!latch_resetb) begin
      rst_low++;
      if (wl != '0) viol++;
    end
    if ($countones(wl) > 1) viol++;
    if (wl != '0) begin
      if (wl != prev_wl) begin
        if (idx != pulse_cnt) order_err++;
        pulse_cnt++;
        cur_w = 0;
        last_idx = idx;
`ifdef CONFIG_LATCH_BANK_READBACK_EN
        if (idx == 2) err_at2 = int'(err);
        if (idx == 3) err_at3 = int'(err);
`endif
      end
      cur_w++;
      if (bl != pat(last_idx)) bl_err++;
    end else if (prev_wl != '0) begin
      if (cur_w != 2) width_err++;
    end
    prev_wl = wl;

    start = 1'b0;
    if (din_ready && word_idx == stall_word && stall_left > 0) begin
      din_valid = 1'b0;
      stall_left--;
      stall_taken++;
      if (wl != '0) stall_viol++;
    end else begin
      din_valid = 1'b1;
    end
    din_data = pat(word_idx);
    if (din_valid && din_ready) word_idx++;
    if (inject_word >= 0 && wl != '0 && last_idx == inject_word && !injected) begin
      start = 1'b1;
      injected = 1'b1;
    end
    if (rst_word >= 0 && wl != '0 && last_idx == rst_word && !rst_hit) begin
      prog_reset = 1'b1;
      rst_hit = 1'b1;
    end else begin
      prog_reset = 1'b0;
    end
`ifdef CONFIG_LATCH_BANK_READBACK_EN
    q_rb = (rb_bad && last_idx == 2) ? ~bl : bl;
`endif
  endtask

  task automatic run_frame(input string tag, input int exp_lat);
    int lat;
    logic seen;
    clear_mon();
    tick();
    start = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (lat < 400 && !seen) begin
      tick();
      lat++;
      if (lat == 1) begin
        check_eq({tag, "_busy_rise"}, int'(busy), 1);
        check_eq({tag, "_done_clear"}, int'(done), 0);
`ifdef CONFIG_LATCH_BANK_READBACK_EN
        check_eq({tag, "_err_clear"}, int'(err), 0);
`endif
      end
      seen = done;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_pulses"}, pulse_cnt, 16);
    check_eq({tag, "_order_err"}, order_err, 0);
    check_eq({tag, "_width_err"}, width_err, 0);
    check_eq({tag, "_bl_err"}, bl_err, 0);
    check_eq({tag, "_wl_viol"}, viol, 0);
    check_eq({tag, "_rst_low"}, rst_low, 4);
    check_eq({tag, "_busy_fall"}, int'(busy), 0);
  endtask

  initial begin
    int n, lat1, w1, rl1, b1;
    prog_reset = 1'b1; start = 1'b0; din_valid = 1'b0; din_data = 8'h00;
    start1 = 1'b0; din_valid1 = 1'b1; din_data1 = 8'h5A;
    stall_word = -1; stall_len = 0; inject_word = -1; rst_word = -1;
    data_mode = 1'b0; rb_bad = 1'b0;
`ifdef CONFIG_LATCH_BANK_READBACK_EN
    q_rb = 8'h00; q_rb1 = 8'h00;
`endif
    clear_mon();
    repeat (3) @(negedge prog_clk);
    check_eq("rst_wl", int'(wl), 0);
    check_eq("rst_bl", int'(bl), 0);
    check_eq("rst_latch_resetb", int'(latch_resetb), 1);
    check_eq("rst_din_ready", int'(din_ready), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    prog_reset = 1'b0;

    run_frame("a5", LAT_FULL);
    repeat (3) tick();
    check_eq("a5_done_sticky", int'(done), 1);
    check_eq("a5_idle_busy", int'(busy), 0);
    check_eq("a5_bl_held", int'(bl), 8'hA5);

    data_mode = 1'b1; stall_word = 3; stall_len = 5;
    run_frame("stall", LAT_FULL + 5);
    check_eq("stall_taken", stall_taken, 5);
    check_eq("stall_wl", stall_viol, 0);
    stall_word = -1; stall_len = 0;

    inject_word = 7;
    run_frame("inj", LAT_FULL);
    check_eq("inj_applied", int'(injected), 1);
    repeat (5) tick();
    check_eq("inj_no_restart", int'(busy), 0);
    check_eq("inj_done_kept", int'(done), 1);
    inject_word = -1;

    clear_mon();
    rst_word = 4;
    tick();
    start = 1'b1;
    n = 0;
    while (!rst_hit && n < 200) begin
      tick();
      n++;
    end
    check_eq("abort_hit", int'(rst_hit), 1);
    tick();
    check_eq("abort_wl", int'(wl), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_done", int'(done), 0);
    check_eq("abort_latch_resetb", int'(latch_resetb), 1);
    check_eq("abort_din_ready", int'(din_ready), 0);
    check_eq("abort_pulses", pulse_cnt, 5);
    rst_word = -1;
    run_frame("after_abort", LAT_FULL);

`ifdef CONFIG_LATCH_BANK_READBACK_EN
    rb_bad = 1'b1;
    run_frame("rb", LAT_FULL);
    check_eq("rb_err_before", err_at2, 0);
    check_eq("rb_err_after", err_at3, 1);
    check_eq("rb_err_sticky", int'(err), 1);
    rb_bad = 1'b0;
    run_frame("rb_clean", LAT_FULL);
    check_eq("rb_clean_err", int'(err), 0);
`endif

    @(negedge prog_clk);
    start1 = 1'b1;
    lat1 = 0; w1 = 0; rl1 = 0; b1 = 0;
    while (lat1 < 100 && !done1) begin
      @(negedge prog_clk);
      start1 = 1'b0;
      lat1++;
`ifdef CONFIG_LATCH_BANK_READBACK_EN
      q_rb1 = bl1;
`endif
      if (!latch_resetb1) rl1++;
      if (wl1[0]) begin
        w1++;
        if (bl1 != 8'h5A) b1++;
      end
    end
    check_eq("small_latency", lat1, LAT_SMALL);
    check_eq("small_pulse_width", w1, 1);
    check_eq("small_rst_low", rl1, 4);
    check_eq("small_bl", b1, 0);
    check_eq("small_busy_fall", int'(busy1), 0);
`ifdef CONFIG_LATCH_BANK_READBACK_EN
    check_eq("small_err", int'(err1), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/config_latch_bank_ctrl.md
CONFIG_LATCH_BANK_CTRL -- requirements
Module: config_latch_bank_ctrl

Interface
REQ-001 SHALL have parameter NUM_BL, default 8: bit-line count, which is also the word width.
REQ-002 SHALL have parameter NUM_WL, default 16: word-line count, which is also the number of words per frame.
REQ-003 SHALL have parameter WL_PULSE_CYCLES, default 2: word-line high time; a value of 0 SHALL be treated as 1.
REQ-004 SHALL have parameter RST_CYCLES, default 4: latch reset low time, in cycles, minimum 1.
REQ-005 SHALL have port prog_clk  in  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port prog_reset  in  1: reset, synchronous and active-high.
REQ-007 SHALL have port start  in  1: one-cycle pulse that begins a frame.
REQ-008 SHALL have port din_valid  in  1: config word valid.
REQ-009 SHALL have port din_data  in  NUM_BL: config word for the current word line.
REQ-010 SHALL have port din_ready  out  1: word accepted when din_valid and din_ready are both high.
REQ-011 SHALL have port latch_resetb  out  1: active-low reset to the latch array.
REQ-012 SHALL have port bl  out  NUM_BL: bit-line drive.
REQ-013 SHALL have port wl  out  NUM_WL: word-line enables, one-hot or zero.
REQ-014 SHALL have port busy  out  1: high from start acceptance until DONE.
REQ-015 SHALL have port done  out  1: frame complete; sticky.

Function
REQ-016 FSM states SHALL be IDLE, LRST, WAIT, SETUP, PULSE, HOLD, DONE.
REQ-017 IDLE: start SHALL go to LRST; busy SHALL rise the next cycle and done SHALL clear.
REQ-018 LRST SHALL drive latch_resetb=0 for exactly RST_CYCLES cycles, then go to WAIT with the column index at 0.
REQ-019 WAIT SHALL drive din_ready=1; on handshake, register din_data into bl and go to SETUP; din_ready SHALL be 0 in every other state.
REQ-020 SETUP SHALL last 1 cycle with bl stable and wl all zero.
REQ-021 PULSE SHALL drive wl[col]=1 for exactly WL_PULSE_CYCLES cycles; bl SHALL stay unchanged.
REQ-022 HOLD SHALL last 1 cycle with wl zero and bl held; then if col==NUM_WL-1 go to DONE, else increment col and go to WAIT.
REQ-023 DONE SHALL set done=1 and busy=0 and go to IDLE; done SHALL stay 1 until the next accepted start.
REQ-024 start SHALL be ignored in any state except IDLE.
REQ-025 No more than one wl bit SHALL be high in any cycle, and wl SHALL never be high while latch_resetb=0.
REQ-026 The column counter SHALL be $clog2(NUM_WL) bits wide, with no wrap beyond NUM_WL-1.
REQ-027 Minimum frame latency with din_valid held high SHALL be 1+RST_CYCLES+NUM_WL*(3+WL_PULSE_CYCLES)+1 cycles, from start to done.

Reset
REQ-028 While prog_reset=1, SHALL set state to IDLE, col to 0, wl to 0, bl to 0, latch_resetb to 1, din_ready, busy and done to 0.
REQ-029 prog_reset mid-frame SHALL abort within the same edge; partially written latches SHALL be left as is, with no trailing wl pulse.

Configuration
REQ-030 Macro CONFIG_LATCH_BANK_READBACK_EN SHALL add input q_rb [NUM_BL] (latch Q of the selected column) and output err [1].
REQ-031 With the macro defined, a VERIFY state SHALL be inserted after HOLD for 1 cycle: q_rb is compared to bl, err is set sticky on mismatch, and err is cleared on start and reset; frame latency SHALL grow by NUM_WL cycles.
REQ-032 Without the macro, q_rb, err and VERIFY SHALL be absent, and timing SHALL be exactly as in REQ-027.

Structure
REQ-033 Package config_latch_bank_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-034 A sub-module config_latch_bank_timer SHALL provide a down-counter shared by LRST and PULSE: load value, count, and a zero flag.
REQ-035 The main module SHALL contain the FSM, col counter, bl register and one-hot wl decode.

Verification
REQ-036 Scenario: defaults, start, din_valid held high, data 8'hA5 for all words -> latch_resetb low 4 cycles; 16 wl pulses each 2 cycles, in order 0..15; bl=8'hA5 during every pulse; done at cycle 1+4+80+1=86.
REQ-037 Scenario: din_valid low 5 cycles before word 3 -> FSM stalls in WAIT with wl=0 and din_ready=1; the rest of the frame is correct; latency +5.
REQ-038 Scenario: start pulsed in PULSE of word 7 -> ignored, no counter or state change; a single frame completes.
REQ-039 Scenario: prog_reset during PULSE of word 4 -> next cycle wl=0, busy=0, done=0, latch_resetb=1; a new start runs a full frame.
REQ-040 Scenario: WL_PULSE_CYCLES=0, NUM_WL=1 -> wl pulse of width 1, and done after 1+RST_CYCLES+4+1 cycles.
REQ-041 Scenario (READBACK_EN): q_rb forced to ~bl on word 2 -> err=1 from VERIFY of word 2 onward, stays 1 after done, and clears on the next start.
